// File: rtl/inner_cnt.sv
// -----------------------------------------------------------------------------
// inner_cnt -- blitter inner-loop (pixel) counter and pass controller.
//
// Sits under the outer-loop sequencer. A GPU-written reload value is loaded
// into a working counter on instart. The counter then decrements once per
// accepted pixel step. When the pass completes, a one-cycle indone pulse is
// raised and the controller returns to idle.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-high reset
//   countld      GPU write strobe for the reload register
//   gpu_din      GPU write data, bit 0 is the LSB of the inner count
//   instart      start one inner pass
//   step         data path finished one pixel this cycle
//   stopped      collision stop; counting is frozen while high
//   statrd       status read strobe
//   indone       registered one-cycle pass-complete pulse
//   inner_busy   high while a pass is running
//   ilast        running and counter == 1 (current step is the last one)
//   icount       live working counter
//   gpu_dout     status read data (always the live counter)
//   gpu_dout_oe  status read drive enable (follows statrd)
// -----------------------------------------------------------------------------
module inner_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             countld,
    input  logic [0:31]      gpu_din,
    input  logic             instart,
    input  logic             step,
    input  logic             stopped,
    input  logic             statrd,
    output logic             indone,
    output logic             inner_busy,
    output logic             ilast,
    output logic [CNT_W-1:0] icount,
    output logic [CNT_W-1:0] gpu_dout,
    output logic             gpu_dout_oe
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_r;
    state_t           state_s;
    logic [CNT_W-1:0] reload_r;
    logic [CNT_W-1:0] icount_r;
    logic [CNT_W-1:0] icount_s;
    logic [CNT_W-1:0] din_cnt_s;
    logic [CNT_W-1:0] load_val_s;
    logic             indone_r;
    logic             busy_r;
    logic             din_unused_s;

    // Upper GPU data bits are not part of the count field.
    assign din_unused_s = ^gpu_din;

    // gpu_din is numbered ascending with bit 0 as LSB, so copy bit by bit
    // into a conventional descending vector rather than slicing.
    always_comb begin
        din_cnt_s = {CNT_W{1'b0}};
        for (int i = 0; i < CNT_W; i++) begin
            din_cnt_s[i] = gpu_din[i];
        end
    end

    // A same-cycle GPU write bypasses the reload register.
    always_comb begin
        if (countld) begin
            load_val_s = din_cnt_s;
        end else begin
            load_val_s = reload_r;
        end
    end

    // Next-state and next-count logic for the pass FSM.
    always_comb begin
        state_s  = state_r;
        icount_s = icount_r;
        case (state_r)
            ST_IDLE: begin
                if (instart) begin
                    state_s  = ST_RUN;
                    icount_s = load_val_s;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_RUN: begin
                // stopped has priority, even over the final step.
                if (step && !stopped) begin
                    icount_s = icount_r - CNT_ONE;
                    if (icount_r == CNT_ONE) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_RUN;
                    end
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DONE: begin
                // Same-cycle restart lets the outer sequencer chain passes.
                if (instart) begin
                    state_s  = ST_RUN;
                    icount_s = load_val_s;
                end else begin
                    state_s  = ST_IDLE;
                    icount_s = {CNT_W{1'b0}};
                end
            end
            default: begin
                state_s  = ST_IDLE;
                icount_s = {CNT_W{1'b0}};
            end
        endcase
    end

    // State, counter and decoded status flags; flags are registered from the
    // next state so indone and inner_busy cannot glitch on state-bit changes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            icount_r <= {CNT_W{1'b0}};
            indone_r <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            icount_r <= icount_s;
            indone_r <= (state_s == ST_DONE);
            busy_r   <= (state_s == ST_RUN);
        end
    end

    // Reload register; writable in any state without touching the counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reload_r <= {CNT_W{1'b0}};
        end else if (countld) begin
            reload_r <= din_cnt_s;
        end else begin
            reload_r <= reload_r;
        end
    end

    assign indone      = indone_r;
    assign inner_busy  = busy_r;
    assign ilast       = busy_r && (icount_r == CNT_ONE);
    assign icount      = icount_r;
    assign gpu_dout    = icount_r;
    assign gpu_dout_oe = statrd;

endmodule

// File: tb/tb_inner_cnt.sv
// -----------------------------------------------------------------------------
// tb_inner_cnt -- directed bench for inner_cnt. Each clock step pushes the
// expected post-edge outputs to a scoreboard queue; after the edge the entry
// is popped and compared with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_inner_cnt;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             countld;
    logic [0:31]      gpu_din;
    logic             instart;
    logic             step;
    logic             stopped;
    logic             statrd;
    logic             indone;
    logic             inner_busy;
    logic             ilast;
    logic [CNT_W-1:0] icount;
    logic [CNT_W-1:0] gpu_dout;
    logic             gpu_dout_oe;

    typedef struct {
        string       tag;
        logic [15:0] ic;
        logic        bz;
        logic        dn;
    } exp_t;

    exp_t sb_q[$];
    int   n_pass = 0;
    int   n_chk  = 0;

    inner_cnt #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .countld     (countld),
        .gpu_din     (gpu_din),
        .instart     (instart),
        .step        (step),
        .stopped     (stopped),
        .statrd      (statrd),
        .indone      (indone),
        .inner_busy  (inner_busy),
        .ilast       (ilast),
        .icount      (icount),
        .gpu_dout    (gpu_dout),
        .gpu_dout_oe (gpu_dout_oe)
    );

    always #5 clk = ~clk;

    // Place a normal binary value onto the ascending-numbered GPU bus.
    function automatic logic [0:31] pack_din(input logic [31:0] v);
        logic [0:31] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[i];
        end
        return r;
    endfunction

    task automatic chk1(input string tag, input string field,
                        input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s %s got %h expected %h", tag, field, got, exp);
    endtask

    task automatic check_now(input exp_t e);
        logic last_exp;
        last_exp = e.bz && (e.ic == 16'h0001);
        chk1(e.tag, "icount",   icount,              e.ic);
        chk1(e.tag, "gpu_dout", gpu_dout,            e.ic);
        chk1(e.tag, "busy",     {15'h0, inner_busy}, {15'h0, e.bz});
        chk1(e.tag, "indone",   {15'h0, indone},     {15'h0, e.dn});
        chk1(e.tag, "ilast",    {15'h0, ilast},      {15'h0, last_exp});
        chk1(e.tag, "oe",       {15'h0, gpu_dout_oe}, {15'h0, statrd});
    endtask

    task automatic drv(input logic cl, input logic [31:0] din, input logic ins,
                       input logic st, input logic sp);
        countld = cl;
        gpu_din = pack_din(din);
        instart = ins;
        step    = st;
        stopped = sp;
    endtask

    task automatic tick(input string tag, input logic [15:0] ic,
                        input logic bz, input logic dn);
        exp_t e;
        sb_q.push_back('{tag, ic, bz, dn});
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check_now(e);
    endtask

    initial begin
        logic [15:0] e_ic;
        reset  = 1'b0;
        statrd = 1'b1;
        drv(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        #1 reset = 1'b1;
        #2 check_now('{"reset", 16'h0000, 1'b0, 1'b0});
        @(posedge clk);
        #1;
        reset  = 1'b0;
        statrd = 1'b0;

        // T1: count 3, step held.
        drv(1'b1, 32'h0000_0003, 1'b0, 1'b0, 1'b0); tick("t1_ld",   16'h0000, 1'b0, 1'b0);
        drv(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);         tick("t1_go",   16'h0003, 1'b1, 1'b0);
        instart = 1'b0;                              tick("t1_s1",   16'h0002, 1'b1, 1'b0);
                                                     tick("t1_s2",   16'h0001, 1'b1, 1'b0);
                                                     tick("t1_dn",   16'h0000, 1'b0, 1'b1);
        step = 1'b0;                                 tick("t1_idle", 16'h0000, 1'b0, 1'b0);

        // T2: count 5, toggled step, stopped pulse, stopped on last step.
        drv(1'b1, 32'h0000_0005, 1'b0, 1'b0, 1'b0); tick("t2_ld",   16'h0000, 1'b0, 1'b0);
        drv(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);         tick("t2_go",   16'h0005, 1'b1, 1'b0);
        drv(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);         tick("t2_a",    16'h0004, 1'b1, 1'b0);
        step = 1'b0;                                 tick("t2_b",    16'h0004, 1'b1, 1'b0);
        step = 1'b1;                                 tick("t2_c",    16'h0003, 1'b1, 1'b0);
        step = 1'b0;                                 tick("t2_d",    16'h0003, 1'b1, 1'b0);
        step = 1'b1; stopped = 1'b1;                 tick("t2_st1",  16'h0003, 1'b1, 1'b0);
                                                     tick("t2_st2",  16'h0003, 1'b1, 1'b0);
        step = 1'b0;                                 tick("t2_st3",  16'h0003, 1'b1, 1'b0);
        step = 1'b1; stopped = 1'b0;                 tick("t2_e",    16'h0002, 1'b1, 1'b0);
        step = 1'b0;                                 tick("t2_f",    16'h0002, 1'b1, 1'b0);
        step = 1'b1;                                 tick("t2_g",    16'h0001, 1'b1, 1'b0);
        stopped = 1'b1;                              tick("t2_stl",  16'h0001, 1'b1, 1'b0);
        stopped = 1'b0;                              tick("t2_dn",   16'h0000, 1'b0, 1'b1);
        step = 1'b0;                                 tick("t2_idle", 16'h0000, 1'b0, 1'b0);

        // T3: count 2, restart in the DONE cycle.
        drv(1'b1, 32'h0000_0002, 1'b0, 1'b0, 1'b0); tick("t3_ld",   16'h0000, 1'b0, 1'b0);
        drv(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);         tick("t3_go",   16'h0002, 1'b1, 1'b0);
        instart = 1'b0;                              tick("t3_s1",   16'h0001, 1'b1, 1'b0);
                                                     tick("t3_dn1",  16'h0000, 1'b0, 1'b1);
        instart = 1'b1;                              tick("t3_rst",  16'h0002, 1'b1, 1'b0);
        instart = 1'b0;                              tick("t3_s2",   16'h0001, 1'b1, 1'b0);
                                                     tick("t3_dn2",  16'h0000, 1'b0, 1'b1);
        step = 1'b0;                                 tick("t3_idle", 16'h0000, 1'b0, 1'b0);

        // T4: zero count via same-cycle bypass runs the full 2^16 steps.
        drv(1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b0); tick("t4_go",   16'h0000, 1'b1, 1'b0);
        drv(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        for (int i = 1; i < 65536; i++) begin
            e_ic = 16'h0000 - 16'(i);
            tick("t4_run", e_ic, 1'b1, 1'b0);
        end
                                                     tick("t4_dn",   16'h0000, 1'b0, 1'b1);
        step = 1'b0;                                 tick("t4_idle", 16'h0000, 1'b0, 1'b0);

        // T5: reload write during RUN leaves the live count alone.
        drv(1'b1, 32'h0000_0009, 1'b0, 1'b0, 1'b0); tick("t5_ld",   16'h0000, 1'b0, 1'b0);
        drv(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);         tick("t5_go",   16'h0009, 1'b1, 1'b0);
        instart = 1'b0;                              tick("t5_s1",   16'h0008, 1'b1, 1'b0);
                                                     tick("t5_s2",   16'h0007, 1'b1, 1'b0);
        drv(1'b1, 32'hABCD_0010, 1'b0, 1'b1, 1'b0);
        statrd = 1'b1;                               tick("t5_wr",   16'h0006, 1'b1, 1'b0);
        countld = 1'b0;
        for (int i = 5; i >= 1; i--) begin
            tick("t5_run", 16'(i), 1'b1, 1'b0);
        end
        statrd = 1'b0;                               tick("t5_dn",   16'h0000, 1'b0, 1'b1);
        step = 1'b0;                                 tick("t5_idle", 16'h0000, 1'b0, 1'b0);
        instart = 1'b1;                              tick("t5_go2",  16'h0010, 1'b1, 1'b0);
        instart = 1'b0;                              tick("t5_hold", 16'h0010, 1'b1, 1'b0);
        step = 1'b1;
        for (int i = 15; i >= 4; i--) begin
            tick("t5_run2", 16'(i), 1'b1, 1'b0);
        end

        // T6: asynchronous reset mid-pass at icount 4.
        step = 1'b0;
        #2 reset = 1'b1;
        #1 check_now('{"t6_async", 16'h0000, 1'b0, 1'b0});
                                                     tick("t6_hold", 16'h0000, 1'b0, 1'b0);
        reset = 1'b0;                                tick("t6_idle", 16'h0000, 1'b0, 1'b0);
        instart = 1'b1;                              tick("t6_go",   16'h0000, 1'b1, 1'b0);
        instart = 1'b0; step = 1'b1;                 tick("t6_s1",   16'hFFFF, 1'b1, 1'b0);
                                                     tick("t6_s2",   16'hFFFE, 1'b1, 1'b0);
                                                     tick("t6_s3",   16'hFFFD, 1'b1, 1'b0);
        step = 1'b0;                                 tick("t6_end",  16'hFFFD, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
